// File: rtl/sr_load_sched_if.sv
// Word-request and i4003 serial-link bundle for sr_load_sched.
// The slave modport is the scheduler side and the master modport is the requester/i4003 environment.
interface sr_load_sched_if #(
  parameter int WIDTH = 10
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             sr_cp;
  logic             sr_data;
  logic             sr_enable;
  logic             sr_sout;
  logic             busy;
  logic             done;
  logic             done_id;
  logic [WIDTH-1:0] rd_data;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, sr_sout,
    input  req0_ready, req1_ready, sr_cp, sr_data, sr_enable,
           busy, done, done_id, rd_data
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, sr_sout,
    output req0_ready, req1_ready, sr_cp, sr_data, sr_enable,
           busy, done, done_id, rd_data
  );
endinterface

// File: rtl/sr_load_sched.sv
// Round-robin loader for the i4003: serialises a granted word MSB first, done pulses at grant+1+2*WIDTH*CP_DIV.
// ready is granted only in IDLE, so requests are held off while busy; SR_READBACK_EN captures the displaced word into rd_data.
module sr_load_sched #(
  parameter int WIDTH  = 10,
  parameter int CP_DIV = 4
) (
  input  logic           sysclk,
  input  logic           poc_pad,
  sr_load_sched_if.slave bus
);

  localparam int         BW      = $clog2(WIDTH + 1);
  localparam logic [7:0] PH_LOAD = 8'(CP_DIV - 1);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, DONE} state_t;

  state_t           state;
  state_t           state_nx;
  logic [7:0]       phase;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic             last_grant;
  logic             pick;
  logic             hs;
  logic             phase_end;
  logic             last_bit;

  // On a tie the requester not served last wins; a lone requester always wins.
  always_comb begin
    pick = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      pick = ~last_grant;
    end else begin
      pick = bus.req1_valid;
    end
  end

  assign hs        = (state == IDLE) && (bus.req0_valid || bus.req1_valid);
  assign phase_end = (phase == 8'd0);
  assign last_bit  = (bit_cnt == BW'(WIDTH - 1));
  assign bus.busy  = (state != IDLE);

  always_ff @(posedge sysclk or posedge poc_pad) begin
    if (poc_pad) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.sr_cp      = 1'b0;
    bus.sr_data    = 1'b0;
    bus.sr_enable  = 1'b0;
    bus.done       = 1'b0;
    bus.done_id    = 1'b0;
    case (state)
      IDLE: begin
        bus.req0_ready = bus.req0_valid & ~pick;
        bus.req1_ready = bus.req1_valid & pick;
        if (hs) begin
          state_nx = SETUP;
        end
      end
      SETUP: begin
        bus.sr_enable = 1'b1;
        bus.sr_data   = shreg[WIDTH-1];
        if (phase_end) begin
          state_nx = HIGH;
        end
      end
      HIGH: begin
        bus.sr_enable = 1'b1;
        bus.sr_cp     = 1'b1;
        bus.sr_data   = shreg[WIDTH-1];
        if (phase_end) begin
          state_nx = last_bit ? DONE : SETUP;
        end
      end
      DONE: begin
        bus.done    = 1'b1;
        bus.done_id = last_grant;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // last_grant doubles as the id of the word in flight.
  always_ff @(posedge sysclk or posedge poc_pad) begin
    if (poc_pad) begin
      phase      <= 8'd0;
      bit_cnt    <= '0;
      shreg      <= '0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            shreg      <= pick ? bus.req1_data : bus.req0_data;
            last_grant <= pick;
            bit_cnt    <= '0;
            phase      <= PH_LOAD;
          end
        end
        SETUP: begin
          phase <= phase_end ? PH_LOAD : phase - 8'd1;
        end
        HIGH: begin
          if (phase_end) begin
            phase   <= PH_LOAD;
            shreg   <= {shreg[WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt + BW'(1);
          end else begin
            phase <= phase - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SR_READBACK_EN
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] rd_q;

  // serial_out is sampled just before each cp rise, while it still shows the bit about to be displaced.
  always_ff @(posedge sysclk or posedge poc_pad) begin
    if (poc_pad) begin
      cap  <= '0;
      rd_q <= '0;
    end else begin
      if (state == SETUP && phase_end) begin
        cap <= {cap[WIDTH-2:0], bus.sr_sout};
      end
      if (state == HIGH && phase_end && last_bit) begin
        rd_q <= cap;
      end
    end
  end

  assign bus.rd_data = rd_q;
`else
  logic unused_sout;
  assign unused_sout = bus.sr_sout;
  assign bus.rd_data = '0;
`endif

endmodule

// File: tb/tb_sr_load_sched.sv
// Scoreboard bench for sr_load_sched: default instance (CP_DIV=4) with an i4003 model, plus a CP_DIV=1 instance.
// Readback expectations follow SR_READBACK_EN.
module tb_sr_load_sched;

  localparam int W   = 10;
  localparam int CPD = 4;

  typedef struct {
    bit         id;
    logic [9:0] data;
    int         t;
  } exp_t;

  logic sysclk;
  logic poc_pad;

  sr_load_sched_if #(.WIDTH(W)) bus ();
  sr_load_sched_if #(.WIDTH(W)) bus1 ();

  sr_load_sched #(.WIDTH(W), .CP_DIV(CPD)) dut (
    .sysclk (sysclk),
    .poc_pad(poc_pad),
    .bus    (bus.slave)
  );

  sr_load_sched #(.WIDTH(W), .CP_DIV(1)) dut1 (
    .sysclk (sysclk),
    .poc_pad(poc_pad),
    .bus    (bus1.slave)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];
  bit   served[$];
  int   hs_q[$];
  int   viol      = 0;
  int   pulses    = 0;
  int   bad_pulse = 0;
  int   hi_cnt    = 0;
  logic [9:0] bits = '0;
  logic       prev_cp = 1'b0;
  logic       hold_bit = 1'b0;
  logic [9:0] model = '0;

  assign bus.sr_sout  = model[9];
  assign bus1.sr_sout = 1'b0;

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  initial forever begin
    @(posedge sysclk);
    cyc++;
  end

  // i4003 behavioural model: shifts serial_in on cp rise while enabled.
  initial forever begin
    @(posedge bus.sr_cp);
    if (bus.sr_enable === 1'b1) model = {model[8:0], bus.sr_data};
  end

  // Monitor: pulse shape, serial bits and scoreboard checks on every done.
  initial forever begin
    @(negedge sysclk);
    if (poc_pad === 1'b1) begin
      pulses = 0; bits = '0; hi_cnt = 0; prev_cp = 1'b0; bad_pulse = 0;
    end else begin
      if (bus.req0_ready === 1'b1 || bus.req1_ready === 1'b1) begin
        hs_q.push_back(cyc);
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) viol++;
      end
      if (bus.sr_cp === 1'b1) begin
        if (!prev_cp) begin
          pulses++;
          bits     = {bits[8:0], bus.sr_data};
          hold_bit = bus.sr_data;
          hi_cnt   = 0;
        end
        hi_cnt++;
        if (bus.sr_data !== hold_bit) bad_pulse++;
      end else if (prev_cp && hi_cnt != CPD) begin
        bad_pulse++;
      end
      prev_cp = bus.sr_cp;
      if (bus.done === 1'b1) begin
        served.push_back(bus.done_id);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_empty: done with no outstanding grant at cycle %0d", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checks += 4;
          if (bus.done_id !== e.id) begin
            errors++;
            $display("FAIL done_id: got %0d expected %0d", bus.done_id, e.id);
          end
          if (cyc - e.t != 2 * W * CPD + 1) begin
            errors++;
            $display("FAIL done_latency: got %0d expected %0d", cyc - e.t, 2 * W * CPD + 1);
          end
          if (bits !== e.data) begin
            errors++;
            $display("FAIL serial_bits: got %h expected %h", bits, e.data);
          end
          if (pulses != W || bad_pulse != 0) begin
            errors++;
            $display("FAIL cp_pulses: got %0d pulses (%0d bad) expected %0d (0 bad)", pulses, bad_pulse, W);
          end
        end
        pulses = 0; bits = '0; bad_pulse = 0;
      end
    end
  end

  task automatic send(input bit id, input logic [9:0] d, output bit ok);
    ok = 1'b0;
    if (id) begin bus.req1_data = d; bus.req1_valid = 1'b1; end
    else    begin bus.req0_data = d; bus.req0_valid = 1'b1; end
    for (int i = 0; i < 400; i++) begin
      @(negedge sysclk);
      if ((id ? bus.req1_ready : bus.req0_ready) === 1'b1) begin ok = 1'b1; break; end
    end
    if (ok) sb.push_back('{id, d, cyc});
    @(posedge sysclk); #1;
    if (id) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge sysclk);
      if (bus.done === 1'b1) begin ok = 1'b1; break; end
    end
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge sysclk); #1 poc_pad = 1'b1;
    @(negedge sysclk);
    @(posedge sysclk); #1 poc_pad = 1'b0;
    sb.delete(); served.delete(); hs_q.delete(); viol = 0;
  endtask

  task automatic test_reset();
    poc_pad = 1'b1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.req0_data = '0; bus.req1_data = '0;
    bus1.req0_valid = 1'b0; bus1.req1_valid = 1'b0; bus1.req0_data = '0; bus1.req1_data = '0;
    repeat (2) @(negedge sysclk);
    checks += 3;
    if ({bus.sr_cp, bus.sr_data, bus.sr_enable} !== 3'b000) begin
      errors++; $display("FAIL reset_sr: got %b expected 000", {bus.sr_cp, bus.sr_data, bus.sr_enable});
    end
    if ({bus.busy, bus.done, bus.done_id, bus.req0_ready, bus.req1_ready} !== 5'b0) begin
      errors++; $display("FAIL reset_ctl: got %b expected 00000",
                         {bus.busy, bus.done, bus.done_id, bus.req0_ready, bus.req1_ready});
    end
    if (bus.rd_data !== 10'h0) begin
      errors++; $display("FAIL reset_rd: got %h expected 000", bus.rd_data);
    end
    @(posedge sysclk); #1 poc_pad = 1'b0;
  endtask

  task automatic test_single();
    bit ok, okd;
    send(1'b0, 10'h2A5, ok);
    wait_done(okd);
    checks++;
    if (!(ok && okd)) begin
      errors++; $display("FAIL single_timeout: grant %0d done %0d expected 1 1", ok, okd);
    end
  endtask

  task automatic test_tie();
    bit ok0, ok1, okd;
    pulse_reset();
    fork
      send(1'b0, 10'h155, ok0);
      send(1'b1, 10'h0AA, ok1);
    join
    wait_done(okd);
    checks += 3;
    if (!(ok0 && ok1 && okd)) begin
      errors++; $display("FAIL tie_timeout: %0d %0d %0d expected 1 1 1", ok0, ok1, okd);
    end
    if (served.size() != 2 || served[0] !== 1'b0 || served[1] !== 1'b1) begin
      errors++; $display("FAIL tie_order: got %0d ids (first %0d) expected 0,1",
                         served.size(), served.size() > 0 ? served[0] : 1'b1);
    end
    if (hs_q.size() != 2 || hs_q[1] - hs_q[0] != 82) begin
      errors++; $display("FAIL tie_spacing: got %0d grants, gap %0d expected 2, 82",
                         hs_q.size(), hs_q.size() == 2 ? hs_q[1] - hs_q[0] : -1);
    end
  endtask

  task automatic test_back_to_back();
    bit a, b, c, d, okd;
    int bad_gap;
    served.delete(); hs_q.delete(); viol = 0;
    fork
      begin send(1'b0, 10'h301, a); send(1'b0, 10'h0F0, b); end
      begin send(1'b1, 10'h1E1, c); send(1'b1, 10'h2AA, d); end
    join
    wait_done(okd);
    bad_gap = 0;
    for (int i = 1; i < hs_q.size(); i++) if (hs_q[i] - hs_q[i-1] != 82) bad_gap++;
    checks += 4;
    if (!(a && b && c && d && okd)) begin
      errors++; $display("FAIL b2b_timeout: %0d%0d%0d%0d%0d expected 11111", a, b, c, d, okd);
    end
    if (served.size() != 4 || {served[0], served[1], served[2], served[3]} !== 4'b0101) begin
      errors++; $display("FAIL b2b_order: got %0d ids expected 0,1,0,1", served.size());
    end
    if (viol != 0) begin
      errors++; $display("FAIL ready_while_busy: got %0d expected 0", viol);
    end
    if (bad_gap != 0 || hs_q.size() != 4) begin
      errors++; $display("FAIL b2b_spacing: got %0d bad gaps of %0d grants expected 0 of 4", bad_gap, hs_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok, okd, reached;
    send(1'b0, 10'h2A5, ok);
    reached = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge sysclk);
      if (pulses == 5) begin reached = 1'b1; break; end
    end
    @(posedge sysclk); #1 poc_pad = 1'b1;
    @(negedge sysclk);
    checks += 2;
    if (!(ok && reached)) begin
      errors++; $display("FAIL mid_setup: grant %0d bit5 %0d expected 1 1", ok, reached);
    end
    if ({bus.sr_cp, bus.sr_data, bus.sr_enable, bus.busy, bus.done, bus.done_id,
         bus.req0_ready, bus.req1_ready} !== 8'b0 || bus.rd_data !== 10'h0) begin
      errors++; $display("FAIL mid_reset_outputs: got %b rd %h expected 0",
                         {bus.sr_cp, bus.sr_data, bus.sr_enable, bus.busy, bus.done, bus.done_id,
                          bus.req0_ready, bus.req1_ready}, bus.rd_data);
    end
    @(posedge sysclk); #1 poc_pad = 1'b0;
    sb.delete(); served.delete();
    send(1'b1, 10'h3FF, ok);
    wait_done(okd);
    checks++;
    if (!(ok && okd) || served.size() != 1 || served[0] !== 1'b1) begin
      errors++; $display("FAIL post_reset_load: grant %0d done %0d served %0d expected 1 1 1", ok, okd, served.size());
    end
  endtask

  task automatic test_readback();
    bit ok, okd;
    logic [9:0] exp_rd;
`ifdef SR_READBACK_EN
    exp_rd = 10'h3C3;
`else
    exp_rd = 10'h000;
`endif
    send(1'b0, 10'h3C3, ok);
    wait_done(okd);
    send(1'b0, 10'h001, ok);
    wait_done(okd);
    checks += 2;
    if (!(ok && okd)) begin
      errors++; $display("FAIL readback_timeout: grant %0d done %0d expected 1 1", ok, okd);
    end
    if (bus.rd_data !== exp_rd) begin
      errors++; $display("FAIL readback_data: got %h expected %h", bus.rd_data, exp_rd);
    end
  endtask

  task automatic test_cpdiv1();
    bit ok, got;
    int t0, k, bad;
    bus1.req0_data = 10'h2A5; bus1.req0_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge sysclk);
      if (bus1.req0_ready === 1'b1) begin ok = 1'b1; break; end
    end
    t0 = cyc;
    @(posedge sysclk); #1 bus1.req0_valid = 1'b0;
    got = 1'b0; k = 0; bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sysclk);
      k++;
      if (bus1.done === 1'b1) begin got = 1'b1; break; end
      if (bus1.sr_cp !== ~k[0]) bad++;
    end
    checks += 3;
    if (!(ok && got)) begin
      errors++; $display("FAIL div1_timeout: grant %0d done %0d expected 1 1", ok, got);
    end
    if (cyc - t0 != 21) begin
      errors++; $display("FAIL div1_latency: got %0d expected 21", cyc - t0);
    end
    if (bad != 0 || bus1.done_id !== 1'b0) begin
      errors++; $display("FAIL div1_cp_toggle: got %0d bad cycles id %0d expected 0, 0", bad, bus1.done_id);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_back_to_back();
    test_reset_mid();
    test_readback();
    test_cpdiv1();
    repeat (4) @(negedge sysclk);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_leftover: got %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
